// File: rtl/mem_arbiter.sv
// Two-master line arbiter: an icache and a dcache share one cacheline adaptor.
// One transaction at a time, with a one-cycle RELEASE gap before rearbitration.
module mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int FAIR   = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERV_I  = 2'd1,
        SERV_D  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t state;
    grant_t last_grant;

    logic   d_req;
    logic   any_req;
    grant_t grant_sel;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        d_req     = d_read | d_write;
        any_req   = i_read | d_req;
        grant_sel = GRANT_I;
        if (i_read && d_req) begin
            // Tie: round-robin hands it to whoever was not served last; otherwise dcache wins.
            if (FAIR != 0 && last_grant == GRANT_D)
                grant_sel = GRANT_I;
            else
                grant_sel = GRANT_D;
        end else if (d_req) begin
            grant_sel = GRANT_D;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_grant <= grant_sel;
                        if (grant_sel == GRANT_D) begin
                            state   <= SERV_D;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_write <= d_write;
                            m_read  <= ~d_write;
                        end else begin
                            state   <= SERV_I;
                            m_addr  <= i_addr;
                            m_read  <= 1'b1;
                            m_write <= 1'b0;
                        end
                    end
                end
                SERV_I, SERV_D: begin
                    // Requests may drop mid-service; only the adaptor ends a transaction.
                    if (m_resp) begin
                        state   <= RELEASE;
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign i_resp  = (state == SERV_I) && m_resp;
    assign d_resp  = (state == SERV_D) && m_resp;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin instance and one dcache-priority
// instance, each driven by a fixed-latency adaptor model.
module tb_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          m_read;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic [LW-1:0] m_rdata = '0;
    logic          m_resp;

    logic          f_i_read = 1'b0;
    logic [AW-1:0] f_i_addr = 32'h0000_0100;
    logic [LW-1:0] f_i_rdata;
    logic          f_i_resp;
    logic          f_d_read = 1'b0;
    logic          f_d_write = 1'b0;
    logic [AW-1:0] f_d_addr = 32'h0000_0200;
    logic [LW-1:0] f_d_wdata = '0;
    logic [LW-1:0] f_d_rdata;
    logic          f_d_resp;
    logic          f_m_read;
    logic          f_m_write;
    logic [AW-1:0] f_m_addr;
    logic [LW-1:0] f_m_wdata;
    logic [LW-1:0] f_m_rdata = '0;
    logic          f_m_resp;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .FAIR(1)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_resp(m_resp)
    );

    mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .FAIR(0)) dut_prio (
        .clk(clk), .rst(rst),
        .i_read(f_i_read), .i_addr(f_i_addr), .i_rdata(f_i_rdata), .i_resp(f_i_resp),
        .d_read(f_d_read), .d_write(f_d_write), .d_addr(f_d_addr), .d_wdata(f_d_wdata),
        .d_rdata(f_d_rdata), .d_resp(f_d_resp),
        .m_read(f_m_read), .m_write(f_m_write), .m_addr(f_m_addr), .m_wdata(f_m_wdata),
        .m_rdata(f_m_rdata), .m_resp(f_m_resp)
    );

    always #5 clk = ~clk;

    // Adaptor model: raises m_resp on the lat-th busy cycle, at the falling edge.
    int   lat = 4;
    int   busy_cnt = 0;
    logic auto_resp = 1'b0;
    logic man_resp = 1'b0;
    assign m_resp = auto_resp | man_resp;

    always @(negedge clk) begin
        if ((m_read || m_write) && !auto_resp) begin
            busy_cnt++;
            if (busy_cnt >= lat) auto_resp = 1'b1;
        end else begin
            auto_resp = 1'b0;
            busy_cnt  = 0;
        end
    end

    int   f_busy_cnt = 0;
    logic f_auto_resp = 1'b0;
    assign f_m_resp = f_auto_resp;

    always @(negedge clk) begin
        if ((f_m_read || f_m_write) && !f_auto_resp) begin
            f_busy_cnt++;
            if (f_busy_cnt >= 2) f_auto_resp = 1'b1;
        end else begin
            f_auto_resp = 1'b0;
            f_busy_cnt  = 0;
        end
    end

    // Monitor samples just after the falling edge, once m_resp and the resp outputs have settled.
    int            i_cnt = 0;
    int            d_cnt = 0;
    int            f_i_cnt = 0;
    int            f_d_cnt = 0;
    int            overlap_err = 0;
    int            addr_changes = 0;
    int            busy_run = 0;
    int            last_busy_len = 0;
    int            gap_run = 0;
    int            min_gap = 99;
    logic          was_busy = 1'b0;
    logic          seen_txn = 1'b0;
    logic [AW-1:0] txn_addr = '0;
    logic [LW-1:0] last_i_rdata = '0;
    logic [LW-1:0] last_d_rdata = '0;
    byte           order_q[$];

    always @(negedge clk) begin
        #2;
        if (m_read && m_write) overlap_err++;
        if (i_resp && d_resp) overlap_err++;
        if (f_i_resp && f_d_resp) overlap_err++;
        if (i_resp) begin
            i_cnt++;
            last_i_rdata = i_rdata;
            order_q.push_back(8'h49);
        end
        if (d_resp) begin
            d_cnt++;
            last_d_rdata = d_rdata;
            order_q.push_back(8'h44);
        end
        if (f_i_resp) f_i_cnt++;
        if (f_d_resp) f_d_cnt++;
        if (m_read || m_write) begin
            if (!was_busy) begin
                txn_addr = m_addr;
                if (seen_txn && gap_run < min_gap) min_gap = gap_run;
                seen_txn = 1'b1;
            end else if (m_addr != txn_addr) begin
                addr_changes++;
            end
            busy_run++;
        end else begin
            if (was_busy) begin
                last_busy_len = busy_run;
                busy_run = 0;
                gap_run  = 0;
            end
            gap_run++;
        end
        was_busy = m_read | m_write;
    end

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!(m_read || m_write) && n < 50) begin
            tick();
            n++;
        end
        check(tag, m_read | m_write, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((m_read || m_write) && n < 100) begin
            tick();
            n++;
        end
        check(tag, m_read | m_write, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [LW-1:0] pat_a;
    logic [LW-1:0] pat_b;
    logic [LW-1:0] pat_c;
    int            snap_i;
    int            snap_d;
    int            base;
    int            n;

    initial begin
        pat_a = {8{32'hA5A5_0001}};
        pat_b = {8{32'h0B0B_1234}};
        pat_c = {8{32'hC3C3_5678}};

        // Reset state
        idle(2);
        check("rst_m_read", m_read, 1'b0);
        check("rst_m_write", m_write, 1'b0);
        check("rst_m_addr", m_addr, '0);
        check("rst_m_wdata", m_wdata, '0);
        check("rst_i_resp", i_resp, 1'b0);
        check("rst_d_resp", d_resp, 1'b0);
        rst = 1'b1;
        idle(2);

        // Icache fill, 4-cycle adaptor latency
        m_rdata = pat_a;
        i_addr  = 32'h0000_0060;
        i_read  = 1'b1;
        wait_start("i_start");
        i_read = 1'b0;
        check("i_m_addr", m_addr, 32'h0000_0060);
        check("i_m_read", m_read, 1'b1);
        check("i_m_write", m_write, 1'b0);
        wait_done("i_done");
        idle(3);
        check("i_busy_len", last_busy_len, 4);
        check("i_resp_cnt", i_cnt, 1);
        check("i_d_resp_cnt", d_cnt, 0);
        check("i_rdata", last_i_rdata, pat_a);

        // Dcache writeback
        d_addr  = 32'h0000_1000;
        d_wdata = pat_b;
        d_write = 1'b1;
        wait_start("dw_start");
        d_write = 1'b0;
        check("dw_m_write", m_write, 1'b1);
        check("dw_m_read", m_read, 1'b0);
        check("dw_m_wdata", m_wdata, pat_b);
        check("dw_m_addr", m_addr, 32'h0000_1000);
        wait_done("dw_done");
        idle(3);
        check("dw_d_resp_cnt", d_cnt, 1);
        check("dw_i_resp_cnt", i_cnt, 1);

        // Read and write together: write wins
        d_addr  = 32'h0000_1040;
        d_wdata = pat_c;
        d_read  = 1'b1;
        d_write = 1'b1;
        wait_start("rw_start");
        d_read  = 1'b0;
        d_write = 1'b0;
        check("rw_m_write", m_write, 1'b1);
        check("rw_m_read", m_read, 1'b0);
        wait_done("rw_done");
        idle(3);
        check("rw_d_resp_cnt", d_cnt, 2);

        // Address held while the requester changes it and drops the request
        m_rdata = pat_c;
        d_addr  = 32'h0000_2000;
        d_read  = 1'b1;
        wait_start("ah_start");
        d_addr = 32'h0000_3000;
        d_read = 1'b0;
        idle(2);
        check("ah_m_addr_mid", m_addr, 32'h0000_2000);
        check("ah_m_read", m_read, 1'b1);
        wait_done("ah_done");
        idle(3);
        check("ah_d_resp_cnt", d_cnt, 3);
        check("ah_d_rdata", last_d_rdata, pat_c);
        check("ah_addr_stable", addr_changes, 0);

        // Round-robin ties after a fresh reset: D, I, D, I
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        order_q.delete();
        seen_txn = 1'b0;
        min_gap  = 99;
        base     = i_cnt + d_cnt;
        i_addr   = 32'h0000_0400;
        d_addr   = 32'h0000_0800;
        i_read   = 1'b1;
        d_read   = 1'b1;
        n = 0;
        while ((i_cnt + d_cnt) < base + 4 && n < 200) begin
            tick();
            n++;
        end
        i_read = 1'b0;
        d_read = 1'b0;
        check("rr_four_done", i_cnt + d_cnt, base + 4);
        wait_done("rr_done");
        idle(3);
        check("rr_order_len", order_q.size(), 4);
        check("rr_grant0", order_q[0], 8'h44);
        check("rr_grant1", order_q[1], 8'h49);
        check("rr_grant2", order_q[2], 8'h44);
        check("rr_grant3", order_q[3], 8'h49);
        check("rr_min_gap", min_gap, 2);

        // Reset while icache waits for the adaptor, then a stray m_resp
        lat    = 20;
        snap_i = i_cnt;
        snap_d = d_cnt;
        i_addr = 32'h0000_0080;
        i_read = 1'b1;
        wait_start("mr_start");
        i_read = 1'b0;
        idle(3);
        rst = 1'b0;
        #1;
        check("mr_m_read", m_read, 1'b0);
        check("mr_m_addr", m_addr, '0);
        check("mr_i_resp", i_resp, 1'b0);
        idle(2);
        rst = 1'b1;
        lat = 4;
        idle(1);
        man_resp = 1'b1;
        #1;
        check("stray_i_resp", i_resp, 1'b0);
        check("stray_d_resp", d_resp, 1'b0);
        tick();
        check("stray_m_read", m_read | m_write, 1'b0);
        man_resp = 1'b0;
        idle(2);
        check("mr_no_i_resp", i_cnt, snap_i);
        check("mr_no_d_resp", d_cnt, snap_d);
        i_addr = 32'h0000_0090;
        i_read = 1'b1;
        wait_start("mr_fresh_start");
        i_read = 1'b0;
        check("mr_fresh_addr", m_addr, 32'h0000_0090);
        wait_done("mr_fresh_done");
        idle(3);
        check("mr_fresh_resp", i_cnt, snap_i + 1);

        // Dcache priority instance: icache starves until dcache drops
        f_i_read = 1'b1;
        f_d_read = 1'b1;
        n = 0;
        while (f_d_cnt < 3 && n < 200) begin
            tick();
            n++;
        end
        f_d_read = 1'b0;
        check("pr_d_cnt", f_d_cnt, 3);
        check("pr_i_starved", f_i_cnt, 0);
        n = 0;
        while (f_i_cnt < 1 && n < 50) begin
            tick();
            n++;
        end
        f_i_read = 1'b0;
        idle(6);
        check("pr_i_served", f_i_cnt, 1);
        check("pr_d_final", f_d_cnt, 3);

        check("no_overlap", overlap_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
